// File: rtl/urx_pkg.sv
// Shared UART receive/transmit definitions: FSM state encoding and parity helper.
package urx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } urx_state_t;

  localparam int unsigned MAX_WIDTH = 8;

  // High when data ones, odd-sense and received parity bit do not balance to zero.
  function automatic logic parity_mismatch(input logic [MAX_WIDTH-1:0] bits,
                                           input logic odd,
                                           input logic par_bit);
    parity_mismatch = (^bits) ^ odd ^ par_bit;
  endfunction

endpackage

// File: rtl/urx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module urx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture of the line, both stages forced high on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      q_r    <= 1'b1;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/urx_fsm.sv
// Oversampling UART receiver FSM: mid-bit sampling, parity/framing/overrun reporting,
// and a one-word holding register acknowledged by rd.
module urx_fsm
  import urx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int OVS     = 16,
  parameter int PAR_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rx,
  input  logic             rd,
  output logic [WIDTH-1:0] data,
  output logic             d_valid,
  output logic             par_err,
  output logic             frm_err,
  output logic             ovr_err,
  output logic             rx_bz
);

  localparam int TC_W = $clog2(OVS);
  localparam int BC_W = $clog2(WIDTH);
  localparam logic [TC_W-1:0] TC_ZERO = TC_W'(0);
  localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);
  localparam logic [TC_W-1:0] TC_HALF = TC_W'(OVS / 2 - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVS - 1);
  localparam logic [BC_W-1:0] BC_ZERO = BC_W'(0);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
  localparam logic            PAR_BIT = (PAR_ODD != 0);

  logic             rxs_s;
  urx_state_t       state_r,    state_nxt_s;
  logic [TC_W-1:0]  tc_r,       tc_nxt_s;
  logic [BC_W-1:0]  bc_r,       bc_nxt_s;
  logic [WIDTH-1:0] shreg_r,    shreg_nxt_s;
  logic             par_bit_r,  par_bit_nxt_s;
  logic             stop_bit_r, stop_bit_nxt_s;
  logic             done_r,     done_nxt_s;
  logic [WIDTH-1:0] data_r,     data_nxt_s;
  logic             d_valid_r,  d_valid_nxt_s;
  logic             par_err_r,  par_err_nxt_s;
  logic             frm_err_r,  frm_err_nxt_s;
  logic             ovr_err_r,  ovr_err_nxt_s;
  logic             rx_bz_r,    rx_bz_nxt_s;

  urx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs_s)
  );

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tc_r       <= TC_ZERO;
      bc_r       <= BC_ZERO;
      shreg_r    <= '0;
      par_bit_r  <= 1'b0;
      stop_bit_r <= 1'b0;
      done_r     <= 1'b0;
      data_r     <= '0;
      d_valid_r  <= 1'b0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      ovr_err_r  <= 1'b0;
      rx_bz_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tc_r       <= tc_nxt_s;
      bc_r       <= bc_nxt_s;
      shreg_r    <= shreg_nxt_s;
      par_bit_r  <= par_bit_nxt_s;
      stop_bit_r <= stop_bit_nxt_s;
      done_r     <= done_nxt_s;
      data_r     <= data_nxt_s;
      d_valid_r  <= d_valid_nxt_s;
      par_err_r  <= par_err_nxt_s;
      frm_err_r  <= frm_err_nxt_s;
      ovr_err_r  <= ovr_err_nxt_s;
      rx_bz_r    <= rx_bz_nxt_s;
    end
  end

  // Next-state and counter logic; every decision waits for an oversample tick
  always_comb begin
    state_nxt_s    = state_r;
    tc_nxt_s       = tc_r;
    bc_nxt_s       = bc_r;
    shreg_nxt_s    = shreg_r;
    par_bit_nxt_s  = par_bit_r;
    stop_bit_nxt_s = stop_bit_r;
    done_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en && !rxs_s) begin
          state_nxt_s = ST_START;
          tc_nxt_s    = TC_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (en && (tc_r == TC_HALF)) begin
          if (rxs_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
            tc_nxt_s    = TC_ZERO;
            bc_nxt_s    = BC_ZERO;
          end
        end else if (en) begin
          tc_nxt_s = tc_r + TC_ONE;
        end else begin
          tc_nxt_s = tc_r;
        end
      end
      ST_DATA: begin
        if (en && (tc_r == TC_LAST)) begin
          shreg_nxt_s[bc_r] = rxs_s;
          tc_nxt_s          = TC_ZERO;
          if (bc_r == BC_LAST) begin
            state_nxt_s = ST_PARITY;
          end else begin
            bc_nxt_s = bc_r + BC_ONE;
          end
        end else if (en) begin
          tc_nxt_s = tc_r + TC_ONE;
        end else begin
          tc_nxt_s = tc_r;
        end
      end
      ST_PARITY: begin
        if (en && (tc_r == TC_LAST)) begin
          par_bit_nxt_s = rxs_s;
          tc_nxt_s      = TC_ZERO;
          state_nxt_s   = ST_STOP;
        end else if (en) begin
          tc_nxt_s = tc_r + TC_ONE;
        end else begin
          tc_nxt_s = tc_r;
        end
      end
      ST_STOP: begin
        // done_r marks the clock after the mid-stop sample, where the word is handed over
        if (done_r) begin
          state_nxt_s = ST_IDLE;
          tc_nxt_s    = TC_ZERO;
        end else if (en && (tc_r == TC_LAST)) begin
          stop_bit_nxt_s = rxs_s;
          done_nxt_s     = 1'b1;
          tc_nxt_s       = TC_ZERO;
        end else if (en) begin
          tc_nxt_s = tc_r + TC_ONE;
        end else begin
          tc_nxt_s = tc_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        tc_nxt_s    = TC_ZERO;
        bc_nxt_s    = BC_ZERO;
      end
    endcase
  end

  // Holding register, error flags and busy indication
  always_comb begin
    data_nxt_s    = data_r;
    d_valid_nxt_s = d_valid_r;
    par_err_nxt_s = par_err_r;
    frm_err_nxt_s = frm_err_r;
    ovr_err_nxt_s = ovr_err_r;
    rx_bz_nxt_s   = (state_nxt_s != ST_IDLE);
    if (done_r) begin
      data_nxt_s    = shreg_r;
      d_valid_nxt_s = 1'b1;
      par_err_nxt_s = parity_mismatch(MAX_WIDTH'(shreg_r), PAR_BIT, par_bit_r);
      frm_err_nxt_s = ~stop_bit_r;
      // an acknowledge landing on the completion clock leaves the overrun flag alone
      if (d_valid_r && !rd) begin
        ovr_err_nxt_s = 1'b1;
      end else begin
        ovr_err_nxt_s = ovr_err_r;
      end
    end else if (rd && d_valid_r) begin
      d_valid_nxt_s = 1'b0;
      ovr_err_nxt_s = 1'b0;
    end else begin
      d_valid_nxt_s = d_valid_r;
    end
  end

  assign data    = data_r;
  assign d_valid = d_valid_r;
  assign par_err = par_err_r;
  assign frm_err = frm_err_r;
  assign ovr_err = ovr_err_r;
  assign rx_bz   = rx_bz_r;

endmodule

// File: tb/tb_urx_fsm.sv
// Self-checking bench for urx_fsm: directed frames plus randomized frames against a
// word-level reference model of the receiver's holding register and flags.
module tb_urx_fsm;

  localparam int WIDTH   = 8;
  localparam int OVS     = 16;
  localparam int PAR_ODD = 0;
  // sync delay + half start bit + remaining bits to mid-stop + handover clock
  localparam int DONE_EDGE = 2 + OVS / 2 + OVS * (WIDTH + 2) + 1;

  logic             clk = 1'b0;
  logic             rst, en, rx, rd;
  logic [WIDTH-1:0] data;
  logic             d_valid, par_err, frm_err, ovr_err, rx_bz;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_data;
  logic       m_dv, m_par, m_frm, m_ovr;

  urx_fsm #(.WIDTH(WIDTH), .OVS(OVS), .PAR_ODD(PAR_ODD)) dut (
    .clk(clk), .rst(rst), .en(en), .rx(rx), .rd(rd),
    .data(data), .d_valid(d_valid), .par_err(par_err), .frm_err(frm_err),
    .ovr_err(ovr_err), .rx_bz(rx_bz)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_data = 8'h00; m_dv = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_done(input logic [7:0] d, input logic pbit, input logic sbit,
                            input logic rd_same);
    if (m_dv && !rd_same) m_ovr = 1'b1;
    m_data = d;
    m_par  = ((($countones(d) + int'(pbit) + PAR_ODD) % 2) != 0);
    m_frm  = (sbit == 1'b0);
    m_dv   = 1'b1;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    if (m_dv) begin
      m_dv  = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  // Sends start, data LSB first, parity, stop; rise_at = edge index where d_valid rose
  task automatic drive_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                             input int div, input int rd_at, output int rise_at);
    logic [10:0] bits;
    logic        prev;
    int          cyc;
    bits    = {sbit, pbit, d, 1'b0};
    cyc     = 0;
    rise_at = -1;
    prev    = d_valid;
    for (int b = 0; b < 11; b++) begin
      rx = bits[b];
      for (int t = 0; t < OVS * div; t++) begin
        en = ((t % div) == 0);
        rd = (cyc == rd_at);
        @(negedge clk);
        if (!prev && d_valid && rise_at < 0) rise_at = cyc;
        prev = d_valid;
        cyc++;
      end
    end
    rd = 1'b0;
    rx = 1'b1;
    for (int t = 0; t < 24 * div; t++) begin
      en = ((t % div) == 0);
      @(negedge clk);
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rx = 1'b0; rd = 1'b1;
    model_clear();
    repeat (4) @(negedge clk);
    n_tests++;
    if (data !== 8'h00) begin
      $display("FAIL reset_data got %h want %h", data, 8'h00); n_fail++;
    end
    n_tests++;
    if ({d_valid, par_err, frm_err, ovr_err, rx_bz} !== 5'b00000) begin
      $display("FAIL reset_flags got %b want %b",
               {d_valid, par_err, frm_err, ovr_err, rx_bz}, 5'b00000); n_fail++;
    end
    rst = 1'b0; rx = 1'b1; rd = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({d_valid, rx_bz} !== 2'b00) begin
      $display("FAIL reset_release got %b want %b", {d_valid, rx_bz}, 2'b00); n_fail++;
    end
  endtask

  task automatic test_basic();
    int rise;
    drive_frame(8'hA5, 1'b0, 1'b1, 1, -1, rise);
    model_done(8'hA5, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (rise !== DONE_EDGE) begin
      $display("FAIL basic_latency got %0d want %0d", rise, DONE_EDGE); n_fail++;
    end
    n_tests++;
    if (data !== m_data) begin
      $display("FAIL basic_data got %h want %h", data, m_data); n_fail++;
    end
    n_tests++;
    if ({d_valid, par_err, frm_err, ovr_err, rx_bz} !== {m_dv, m_par, m_frm, m_ovr, 1'b0}) begin
      $display("FAIL basic_flags got %b want %b", {d_valid, par_err, frm_err, ovr_err, rx_bz},
               {m_dv, m_par, m_frm, m_ovr, 1'b0}); n_fail++;
    end
    do_rd();
    n_tests++;
    if (d_valid !== m_dv) begin
      $display("FAIL basic_rd got %b want %b", d_valid, m_dv); n_fail++;
    end
  endtask

  task automatic test_parity();
    int rise;
    logic [7:0]  words [2];
    logic        pbits [2];
    words[0] = 8'h3C; pbits[0] = 1'b1;
    words[1] = 8'h00; pbits[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_frame(words[i], pbits[i], 1'b1, 1, -1, rise);
      model_done(words[i], pbits[i], 1'b1, 1'b0);
      n_tests++;
      if ({data, par_err, d_valid} !== {m_data, m_par, m_dv}) begin
        $display("FAIL parity_%0d got %h/%b/%b want %h/%b/%b", i, data, par_err, d_valid,
                 m_data, m_par, m_dv); n_fail++;
      end
      do_rd();
    end
  endtask

  task automatic test_false_start();
    int   bz_cnt;
    logic dv_seen;
    bz_cnt  = 0;
    dv_seen = 1'b0;
    rx = 1'b0;
    for (int t = 0; t < 36; t++) begin
      if (t == 6) rx = 1'b1;
      @(negedge clk);
      if (rx_bz) bz_cnt++;
      if (d_valid) dv_seen = 1'b1;
    end
    n_tests++;
    if (bz_cnt !== OVS / 2) begin
      $display("FAIL false_start_bz got %0d want %0d", bz_cnt, OVS / 2); n_fail++;
    end
    n_tests++;
    if ({dv_seen, rx_bz} !== 2'b00) begin
      $display("FAIL false_start_idle got %b want %b", {dv_seen, rx_bz}, 2'b00); n_fail++;
    end
  endtask

  task automatic test_overrun();
    int rise;
    drive_frame(8'h11, 1'b0, 1'b1, 1, -1, rise);
    model_done(8'h11, 1'b0, 1'b1, 1'b0);
    drive_frame(8'h22, 1'b0, 1'b1, 1, -1, rise);
    model_done(8'h22, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({data, d_valid, ovr_err} !== {m_data, m_dv, m_ovr}) begin
      $display("FAIL overrun got %h/%b/%b want %h/%b/%b", data, d_valid, ovr_err,
               m_data, m_dv, m_ovr); n_fail++;
    end
    do_rd();
    n_tests++;
    if ({d_valid, ovr_err} !== {m_dv, m_ovr}) begin
      $display("FAIL overrun_rd got %b want %b", {d_valid, ovr_err}, {m_dv, m_ovr}); n_fail++;
    end
  endtask

  task automatic test_frame_err();
    int rise;
    drive_frame(8'h55, 1'b0, 1'b0, 1, -1, rise);
    model_done(8'h55, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({data, d_valid, frm_err, par_err, rx_bz} !== {m_data, m_dv, m_frm, m_par, 1'b0}) begin
      $display("FAIL frame_err got %h/%b want %h/%b", data, {d_valid, frm_err, par_err, rx_bz},
               m_data, {m_dv, m_frm, m_par, 1'b0}); n_fail++;
    end
    do_rd();
  endtask

  task automatic test_rd_collide();
    int         rise;
    logic [7:0] words [4];
    logic       rdc   [4];
    words[0] = 8'h0F; rdc[0] = 1'b0;
    words[1] = 8'h77; rdc[1] = 1'b1;
    words[2] = 8'h01; rdc[2] = 1'b0;
    words[3] = 8'h80; rdc[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_frame(words[i], ^words[i], 1'b1, 1, rdc[i] ? DONE_EDGE : -1, rise);
      model_done(words[i], ^words[i], 1'b1, rdc[i]);
      n_tests++;
      if ({data, d_valid, ovr_err, par_err} !== {m_data, m_dv, m_ovr, m_par}) begin
        $display("FAIL rd_collide_%0d got %h/%b want %h/%b", i, data, {d_valid, ovr_err, par_err},
                 m_data, {m_dv, m_ovr, m_par}); n_fail++;
      end
    end
    do_rd();
  endtask

  task automatic test_reset_mid();
    int rise;
    drive_frame(8'h42, 1'b0, 1'b1, 1, -1, rise);
    model_done(8'h42, 1'b0, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (OVS) @(negedge clk);
    rx = 1'b1;
    repeat (OVS * 4 + OVS / 2) @(negedge clk);
    n_tests++;
    if ({rx_bz, d_valid} !== {1'b1, m_dv}) begin
      $display("FAIL reset_mid_busy got %b want %b", {rx_bz, d_valid}, {1'b1, m_dv}); n_fail++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_tests++;
    if ({data, d_valid, par_err, frm_err, ovr_err, rx_bz} !== {8'h00, 5'b00000}) begin
      $display("FAIL reset_mid_clear got %h/%b want %h/%b", data,
               {d_valid, par_err, frm_err, ovr_err, rx_bz}, 8'h00, 5'b00000); n_fail++;
    end
    repeat (OVS * 8) @(negedge clk);
    drive_frame(8'h81, 1'b0, 1'b1, 1, -1, rise);
    model_done(8'h81, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({data, d_valid, par_err, frm_err, ovr_err} !== {m_data, m_dv, m_par, m_frm, m_ovr}) begin
      $display("FAIL reset_mid_next got %h/%b want %h/%b", data,
               {d_valid, par_err, frm_err, ovr_err}, m_data, {m_dv, m_par, m_frm, m_ovr}); n_fail++;
    end
    do_rd();
  endtask

  task automatic test_random();
    int         rise, div;
    logic [7:0] d;
    logic       pbit, sbit;
    for (int i = 0; i < 12; i++) begin
      div  = $urandom_range(1, 2);
      d    = 8'($urandom);
      pbit = (($countones(d) % 2) != 0);
      if ($urandom_range(0, 4) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 6) != 0);
      drive_frame(d, pbit, sbit, div, -1, rise);
      model_done(d, pbit, sbit, 1'b0);
      n_tests++;
      if (data !== m_data) begin
        $display("FAIL random_%0d_data got %h want %h", i, data, m_data); n_fail++;
      end
      n_tests++;
      if ({d_valid, par_err, frm_err, ovr_err, rx_bz} !== {m_dv, m_par, m_frm, m_ovr, 1'b0}) begin
        $display("FAIL random_%0d_flags got %b want %b", i,
                 {d_valid, par_err, frm_err, ovr_err, rx_bz}, {m_dv, m_par, m_frm, m_ovr, 1'b0});
        n_fail++;
      end
      if ($urandom_range(0, 1) == 1) begin
        do_rd();
        n_tests++;
        if ({d_valid, ovr_err} !== {m_dv, m_ovr}) begin
          $display("FAIL random_%0d_rd got %b want %b", i, {d_valid, ovr_err}, {m_dv, m_ovr});
          n_fail++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_overrun();
    test_frame_err();
    test_rd_collide();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
